gpu_sequencer: RTL and testbench

Parametrised instruction sequencer for the mini shader core. It holds a host-loadable instruction memory and runs a fetch/execute FSM. Datapath instructions go out on a ready/valid issue bus under a lane mask, and accelerator dispatch is spread over `NUM_ENGINES` start/done channels. Counted loops, a lane-mask register, engine timeouts and error reporting are resolved locally. It sits between the host/testbench and the lane datapath (ALUs, regfile, scratchpad arbiter).

---
 rtl/gpu_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_gpu_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_sequencer.sv
// Instruction sequencer for the mini shader core: host-loaded IMEM, fetch/execute FSM,
// ready/valid datapath issue, accelerator start/done dispatch, counted loops and error capture.
module gpu_sequencer #(
  parameter int         LANES       = 4,
  parameter int         IMEM_DEPTH  = 64,
  parameter int         NUM_ENGINES = 2,
  parameter int         LOOP_DEPTH  = 2,
  parameter int         TIMEOUT     = 1024,
  parameter logic [5:0] OPC_ACCEL   = 6'h30,
  parameter logic [5:0] OPC_SETMASK = 6'h31,
  parameter logic [5:0] OPC_LOOP    = 6'h32,
  parameter logic [5:0] OPC_ENDLOOP = 6'h33
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [31:0]                   issue_instr,
  output logic [LANES-1:0]              issue_mask,
  output logic [$clog2(IMEM_DEPTH)-1:0] issue_pc,
  output logic [NUM_ENGINES-1:0]        eng_start,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [2:0]                    err_code
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int SW = $clog2(LOOP_DEPTH + 1);
  localparam int LW = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
  localparam int LN = 2 ** LW;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AW-1:0] PC_LAST = AW'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_ERROR} state_t;

  state_t                 state, state_nxt;
  logic [31:0]            imem [IMEM_DEPTH];
  logic [31:0]            ir;
  logic [AW-1:0]          pc, ir_pc, pc_nxt;
  logic [LANES-1:0]       lane_mask;
  logic [AW-1:0]          lstart [LN];
  logic [7:0]             lcnt [LN];
  logic [SW-1:0]          sp;
  logic [LW-1:0]          top;
  logic [NUM_ENGINES-1:0] sel_oh, dst_oh;
  logic [TW-1:0]          tcnt;
  logic [5:0]             opc, dst;
  logic [7:0]             imm;
  logic                   is_halt, is_ctrl;
  logic                   adv, fin, push, pop, dec, set_mask, err_set;
  logic [2:0]             code_nxt;

  assign opc     = ir[31:26];
  assign dst     = ir[25:20];
  assign imm     = ir[7:0];
  assign is_halt = (ir == 32'd0);
  assign is_ctrl = (opc == OPC_ACCEL) || (opc == OPC_SETMASK) ||
                   (opc == OPC_LOOP)  || (opc == OPC_ENDLOOP);
  assign top     = LW'(sp - 1'b1);

  // Out-of-range engine indices leave the one-hot vector empty
  always_comb begin
    dst_oh = '0;
    for (int i = 0; i < NUM_ENGINES; i++) dst_oh[i] = (dst == 6'(i));
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      lane_mask <= '1;
      sp        <= '0;
      sel_oh    <= '0;
      tcnt      <= '0;
      err       <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if ((state == S_IDLE || state == S_ERROR) && start) begin
        pc        <= '0;
        lane_mask <= '1;
        sp        <= '0;
        err       <= 1'b0;
        err_code  <= 3'd0;
      end
      if (state == S_FETCH) begin
        ir    <= imem[pc];
        ir_pc <= pc;
      end
      if (set_mask) lane_mask <= imm[LANES-1:0];
      if (push) sp <= sp + 1'b1;
      if (pop)  sp <= sp - 1'b1;
      if (state == S_EXEC && state_nxt == S_WAIT) begin
        sel_oh <= dst_oh;
        tcnt   <= '0;
      end else if (state == S_WAIT) begin
        tcnt <= tcnt + 1'b1;
      end
      if (err_set && !err) begin
        err      <= 1'b1;
        err_code <= code_nxt;
      end
    end
  end

  // Instruction memory and loop stack carry no reset
  always_ff @(posedge clk) begin
    if (imem_we && !busy) imem[imem_waddr] <= imem_wdata;
    if (push) begin
      lstart[sp[LW-1:0]] <= pc + 1'b1;
      lcnt[sp[LW-1:0]]   <= imm;
    end
    if (dec) lcnt[top] <= lcnt[top] - 8'd1;
  end

  // Next-state logic; adv requests PC+1, which ends the program at the last word
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    adv       = 1'b0;
    fin       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    dec       = 1'b0;
    set_mask  = 1'b0;
    err_set   = 1'b0;
    code_nxt  = 3'd0;
    case (state)
      S_IDLE, S_ERROR: if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_halt) begin
          state_nxt = S_IDLE;
          fin       = 1'b1;
        end else if (opc == OPC_SETMASK) begin
          set_mask = 1'b1;
          adv      = 1'b1;
        end else if (opc == OPC_LOOP) begin
          if (sp == SW'(LOOP_DEPTH)) begin
            err_set = 1'b1;
            code_nxt = 3'd1;
          end else begin
            push = 1'b1;
            adv  = 1'b1;
          end
        end else if (opc == OPC_ENDLOOP) begin
          if (sp == '0) begin
            err_set  = 1'b1;
            code_nxt = 3'd2;
          end else if (lcnt[top] > 8'd1) begin
            dec       = 1'b1;
            pc_nxt    = lstart[top];
            state_nxt = S_FETCH;
          end else begin
            pop = 1'b1;
            adv = 1'b1;
          end
        end else if (opc == OPC_ACCEL) begin
          if (dst_oh == '0) begin
            err_set  = 1'b1;
            code_nxt = 3'd3;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (lane_mask == '0 || issue_ready) begin
          adv = 1'b1;
        end
      end
      S_WAIT: begin
        if ((eng_done & sel_oh) != '0) begin
          adv = 1'b1;
        end else if (TIMEOUT != 0 && tcnt == TLAST) begin
          err_set  = 1'b1;
          code_nxt = 3'd4;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (err_set) state_nxt = S_ERROR;
    if (adv) begin
      if (pc == PC_LAST) begin
        state_nxt = S_IDLE;
        fin       = 1'b1;
      end else begin
        pc_nxt    = pc + 1'b1;
        state_nxt = S_FETCH;
      end
    end
  end

  // Output decode
  always_comb begin
    issue_valid = (state == S_EXEC) && !is_halt && !is_ctrl && (lane_mask != '0);
    eng_start   = (state == S_EXEC && opc == OPC_ACCEL) ? dst_oh : '0;
    issue_instr = ir;
    issue_mask  = lane_mask;
    issue_pc    = ir_pc;
    busy        = (state == S_FETCH) || (state == S_EXEC) || (state == S_WAIT);
    done        = fin;
  end
endmodule

// File: tb/tb_gpu_sequencer.sv
// Scoreboard bench for gpu_sequencer: expected issues are queued when a program is loaded
// and popped as the issue bus handshakes; timing, dispatch and error results are checked per run.
module tb_gpu_sequencer;
  localparam logic [5:0] ADD = 6'h01, MUL = 6'h02, STO = 6'h05;
  localparam logic [5:0] ACC = 6'h30, SETM = 6'h31, LOOP = 6'h32, ENDL = 6'h33;

  logic        clk = 1'b0;
  logic        rst, start, imem_we, issue_ready;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [3:0]  issue_mask;
  logic [5:0]  issue_pc;
  logic [1:0]  eng_start, eng_done;
  logic        busy, done, err;
  logic [2:0]  err_code;

  gpu_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_mask(issue_mask), .issue_pc(issue_pc),
    .eng_start(eng_start), .eng_done(eng_done), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0, stall_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] prog[$];
  int          done_cyc, err_cyc, st_cnt, st_cyc;
  logic [1:0]  st_val;
  logic        err_at1, busy_after;
  logic [31:0] w_add, w_mul, w_sto;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [5:0] opc, input logic [5:0] dst,
                                      input logic [7:0] imm);
    return {opc, dst, 6'd3, 6'd4, imm};
  endfunction

  function automatic logic [63:0] mk(input logic [31:0] w, input int pc, input logic [3:0] m);
    logic [5:0] p;
    p = pc[5:0];
    return {22'd0, w, p, m};
  endfunction

  // Issue-bus monitor: the head of the queue must be on the bus for every offered cycle
  always @(negedge clk) begin
    if (!rst && issue_valid) begin
      if (exp_q.size() == 0) begin
        chk("issue_extra", 64'(issue_valid), 64'd0);
      end else begin
        chk("issue_bus", 64'({issue_instr, issue_pc, issue_mask}), exp_q[0]);
        if (issue_ready) void'(exp_q.pop_front());
        else stall_cnt++;
      end
    end
  end

  task automatic check_rst(input string tag);
    chk(tag, 64'({issue_valid, issue_instr, issue_mask, issue_pc, eng_start, busy, done, err,
                  err_code}),
        64'({1'b0, 32'd0, 4'hf, 6'd0, 2'd0, 3'd0, 3'd0}));
  endtask

  task automatic wr(input int a, input logic [31:0] w);
    imem_we    = 1'b1;
    imem_waddr = a[5:0];
    imem_wdata = w;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  task automatic load();
    for (int i = 0; i < prog.size(); i++) wr(i, prog[i]);
  endtask

  // Start a program and step it for at most budget cycles; cycle 1 is FETCH of PC 0.
  task automatic run(input int budget, input int d0, input int d1, input int rlo_a,
                     input int rlo_b, input int stop_at);
    done_cyc = 0; err_cyc = 0; st_cnt = 0; st_cyc = 0; st_val = 2'b00;
    err_at1 = 1'b1; busy_after = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      eng_done    = {(k == d1), (k == d0)};
      issue_ready = !(k >= rlo_a && k <= rlo_b);
      @(negedge clk);
      if (k == 1) err_at1 = err;
      if (eng_start != 2'b00) begin
        st_cnt++;
        st_val = eng_start;
        st_cyc = k;
      end
      if (done) done_cyc = k;
      if (err) err_cyc = k;
      if (done || err || k == stop_at) break;
      @(posedge clk);
      #1;
    end
    eng_done    = 2'b00;
    issue_ready = 1'b1;
    if (done_cyc != 0) begin
      @(negedge clk);
      busy_after = busy;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    issue_ready = 1'b1; eng_done = 2'b00;
    w_add = ins(ADD, 6'd5, 8'd0);
    w_mul = ins(MUL, 6'd6, 8'd1);
    w_sto = ins(STO, 6'd7, 8'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rst("rst_init");
    rst = 1'b0;

    // Straight-line datapath program
    prog = '{w_add, w_mul, w_sto, 32'd0};
    load();
    exp_q.push_back(mk(w_add, 0, 4'hf));
    exp_q.push_back(mk(w_mul, 1, 4'hf));
    exp_q.push_back(mk(w_sto, 2, 4'hf));
    run(40, 0, 0, 0, 0, 0);
    chk("t1_done_cyc", 64'(done_cyc), 64'd8);
    chk("t1_busy_after", 64'(busy_after), 64'd0);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // Counted loop of three
    prog = '{ins(LOOP, 6'd0, 8'd3), w_add, ins(ENDL, 6'd0, 8'd0), 32'd0};
    load();
    repeat (3) exp_q.push_back(mk(w_add, 1, 4'hf));
    run(60, 0, 0, 0, 0, 0);
    chk("t2_done_cyc", 64'(done_cyc), 64'd16);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_err", 64'(err), 64'd0);

    // Lane mask: zero mask skips, 0101 mask issues
    prog = '{ins(SETM, 6'd0, 8'h00), w_add, ins(SETM, 6'd0, 8'h05), w_add, 32'd0};
    load();
    exp_q.push_back(mk(w_add, 3, 4'b0101));
    run(40, 0, 0, 0, 0, 0);
    chk("t3_done_cyc", 64'(done_cyc), 64'd10);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // Accelerator dispatch with a spurious done, then a bad engine index
    prog = '{ins(ACC, 6'd1, 8'd0), w_add, ins(ACC, 6'd2, 8'd0), 32'd0};
    load();
    exp_q.push_back(mk(w_add, 1, 4'hf));
    run(40, 3, 5, 0, 0, 0);
    chk("t4_start_cnt", 64'(st_cnt), 64'd1);
    chk("t4_start_val", 64'(st_val), 64'd2);
    chk("t4_start_cyc", 64'(st_cyc), 64'd2);
    chk("t4_err_cyc", 64'(err_cyc), 64'd10);
    chk("t4_err_code", 64'(err_code), 64'd3);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Engine timeout, then restart from the error state
    prog = '{ins(ACC, 6'd0, 8'd0), 32'd0};
    load();
    run(60, 0, 0, 0, 0, 0);
    chk("t5_start_val", 64'(st_val), 64'd1);
    chk("t5_err_cyc", 64'(err_cyc), 64'd19);
    chk("t5_err_code", 64'(err_code), 64'd4);
    run(40, 4, 0, 0, 0, 0);
    chk("t5_err_cleared", 64'(err_at1), 64'd0);
    chk("t5_done_cyc", 64'(done_cyc), 64'd6);
    chk("t5_err_end", 64'({err, err_code}), 64'd0);

    // Issue stall, then reset during ACCEL_WAIT, then rerun from intact IMEM
    prog = '{w_add, ins(ACC, 6'd0, 8'd0), 32'd0};
    load();
    stall_cnt = 0;
    exp_q.push_back(mk(w_add, 0, 4'hf));
    run(40, 0, 0, 2, 5, 10);
    chk("t6_stall_cnt", 64'(stall_cnt), 64'd4);
    chk("t6_start_cyc", 64'(st_cyc), 64'd8);
    chk("t6_busy_wait", 64'(busy), 64'd1);
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_rst("t6_rst_mid");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_rst("t6_rst_after");
    exp_q.push_back(mk(w_add, 0, 4'hf));
    run(40, 5, 0, 0, 0, 0);
    chk("t6_rerun_done", 64'(done_cyc), 64'd7);
    chk("t6_rerun_start", 64'(st_cyc), 64'd4);
    chk("t6_rerun_q", 64'(exp_q.size()), 64'd0);

    // ENDLOOP underflow
    prog = '{ins(ENDL, 6'd0, 8'd0), 32'd0};
    load();
    run(20, 0, 0, 0, 0, 0);
    chk("t7_err_cyc", 64'(err_cyc), 64'd3);
    chk("t7_err_code", 64'(err_code), 64'd2);

    // Loop stack overflow at depth 2
    prog = '{ins(LOOP, 6'd0, 8'd2), ins(LOOP, 6'd0, 8'd2), ins(LOOP, 6'd0, 8'd2), 32'd0};
    load();
    run(20, 0, 0, 0, 0, 0);
    chk("t8_err_cyc", 64'(err_cyc), 64'd7);
    chk("t8_err_code", 64'(err_code), 64'd1);

    // Loop count of zero runs the body once
    prog = '{ins(LOOP, 6'd0, 8'd0), w_add, ins(ENDL, 6'd0, 8'd0), 32'd0};
    load();
    exp_q.push_back(mk(w_add, 1, 4'hf));
    run(40, 0, 0, 0, 0, 0);
    chk("t9_done_cyc", 64'(done_cyc), 64'd8);
    chk("t9_q_empty", 64'(exp_q.size()), 64'd0);

    // No HALT anywhere: the program ends after the last IMEM word
    prog.delete();
    for (int i = 0; i < 64; i++) begin
      prog.push_back(ins(ADD, 6'd1, 8'(i)));
      exp_q.push_back(mk(ins(ADD, 6'd1, 8'(i)), i, 4'hf));
    end
    load();
    run(200, 0, 0, 0, 0, 0);
    chk("t10_done_cyc", 64'(done_cyc), 64'd128);
    chk("t10_q_empty", 64'(exp_q.size()), 64'd0);
    chk("t10_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
